lfsr_prbs_ctrl: RTL

//  Command-driven sequencer around a Galois LFSR. Accepts LOAD_SEED / RUN / STOP commands,

---
 rtl/lfsr_ctrl_pkg.sv | 22 ++
 rtl/lfsr_step.sv | 36 +++
 rtl/lfsr_prbs_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// Shared types for the PRBS sequencer: command opcodes, controller states
// and default LFSR parameters.
package lfsr_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP       = 2'd0,
        OP_LOAD_SEED = 2'd1,
        OP_RUN       = 2'd2,
        OP_STOP      = 2'd3
    } cmd_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int          DEF_WIDTH = 16;
    localparam logic [15:0] DEF_TAPS  = 16'hB400;
    localparam logic [15:0] DEF_SEED  = 16'hACE1;
    localparam int          DEF_CNT_W = 16;

endpackage

// File: rtl/lfsr_step.sv
// Galois (right-shift) LFSR register with synchronous load and step enable.
// Load has priority over step.
module lfsr_step #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] nxt;

    always_comb begin
        nxt = '0;
        nxt[WIDTH-1] = state[0];
        for (int i = 0; i < WIDTH - 1; i++) begin
            nxt[i] = state[i+1] ^ (TAPS[i] & state[0]);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= SEED;
        end else if (load) begin
            state <= load_val;
        end else if (en) begin
            state <= nxt;
        end
    end

endmodule

// File: rtl/lfsr_prbs_ctrl.sv
// Command-driven PRBS sequencer: streams N LFSR states on a valid/ready
// port, flags the final beat and guards against zero seeds and mid-run commands.
module lfsr_prbs_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS,
    parameter logic [WIDTH-1:0] SEED  = DEF_SEED,
    parameter int               CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             lockup_err,
    output logic             cmd_err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_d, lock_d, cerr_d;
    logic             step_en, load_en;
    logic             hs, is_last;
    cmd_op_e          op;
    logic [CNT_W-1:0] cnt;

    assign op        = cmd_op_e'(cmd_op);
    assign cnt       = cmd_data[CNT_W-1:0];
    assign cmd_ready = 1'b1;
    assign busy      = (state_q == ST_RUN);
    assign out_valid = busy;
    assign is_last   = (rem_q == CNT_W'(1));
    assign out_last  = busy & is_last;
    assign hs        = out_valid & out_ready;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_b    (rst_b),
        .en       (step_en),
        .load     (load_en),
        .load_val (cmd_data),
        .state    (out_data)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        lock_d  = lockup_err;
        cerr_d  = cmd_err;
        step_en = 1'b0;
        load_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (op)
                        OP_LOAD_SEED: begin
                            if (|cmd_data) load_en = 1'b1;
                            else           lock_d  = 1'b1;
                        end
                        OP_RUN: begin
                            if (|cnt) begin
                                rem_d   = cnt;
                                state_d = ST_RUN;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (hs) begin
                    step_en = 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (is_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                // STOP folds into the same done pulse as a coincident last beat
                if (cmd_valid) begin
                    case (op)
                        OP_STOP: begin
                            state_d = ST_IDLE;
                            rem_d   = '0;
                            done_d  = 1'b1;
                        end
                        OP_LOAD_SEED, OP_RUN: cerr_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            done       <= 1'b0;
            lockup_err <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            done       <= done_d;
            lockup_err <= lock_d;
            cmd_err    <= cerr_d;
        end
    end

endmodule
